// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction/data line-memory arbiter.
package imem_arbiter_pkg;

    localparam int WORD_SIZE       = 32;
    localparam int CACHE_LINE_SIZE = 128;
    localparam int ARB_TIMEOUT     = 64;
    localparam int NUM_PORTS       = 2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    // One requester's view of the arbiter: request flag plus its byte address.
    typedef struct packed {
        logic                 vld;
        logic [WORD_SIZE-1:0] addr;
    } arb_req_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker. Purely combinational; gnt is only meaningful
// when at least one request bit is set. With rr_en low, port 0 always wins.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       rr_en,
    output logic       gnt
);

    // Contention goes to the port that did not win last time; a lone requester always wins.
    always_comb begin
        gnt = 1'b0;
        if (req[0] && req[1]) begin
            gnt = rr_en ? ~last_grant : 1'b0;
        end else if (req[1]) begin
            gnt = 1'b1;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Serialises I-cache (port 0) and D-cache (port 1) line fills onto the single
// multi-cycle line memory. Holds Read until Ready, registers the returned line
// and returns it to the winner with a one-cycle done pulse. A stuck memory is
// abandoned after TIMEOUT_CYCLES busy cycles and flagged on a sticky err.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT,
    parameter bit RR_EN          = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0,
    input  logic [WORD_SIZE-1:0]       addr0,
    input  logic                       req1,
    input  logic [WORD_SIZE-1:0]       addr1,
    output logic                       done0,
    output logic                       done1,
    output logic [CACHE_LINE_SIZE-1:0] line_out,
    output logic                       err,
    output logic                       mem_read,
    output logic [WORD_SIZE-1:0]       mem_addr,
    input  logic                       mem_ready,
    input  logic [CACHE_LINE_SIZE-1:0] mem_line
);

    localparam int             CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    arb_state_e                 state_q, state_d;
    arb_req_t [NUM_PORTS-1:0]   port_req;
    logic     [NUM_PORTS-1:0]   req_vec;
    logic                       pick;
    logic                       any_req;
    logic                       mem_hit;
    logic                       timeout_hit;

    logic                       gnt_q, gnt_d;
    logic                       last_grant_q, last_grant_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       mem_read_d;
    logic [WORD_SIZE-1:0]       mem_addr_d;
    logic [CACHE_LINE_SIZE-1:0] line_d;
    logic                       err_d;
    logic                       done0_d, done1_d;

    assign port_req[0] = '{vld: req0, addr: addr0};
    assign port_req[1] = '{vld: req1, addr: addr1};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_req
        assign req_vec[p] = port_req[p].vld;
    end

    assign any_req = |req_vec;

    arb_rr2 u_pick (
        .req        (req_vec),
        .last_grant (last_grant_q),
        .rr_en      (RR_EN),
        .gnt        (pick)
    );

    // Ready wins over timeout when both land in the same busy cycle.
    assign mem_hit     = (state_q == ARB_BUSY) && mem_ready;
    assign timeout_hit = (state_q == ARB_BUSY) && !mem_ready && (cnt_q == CNT_LAST);

    // State register; reset drops straight back to IDLE even mid-transaction.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ARB_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: IDLE -> BUSY on any request, BUSY -> RESP on ready or timeout, RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (any_req)                state_d = ARB_BUSY;
            ARB_BUSY: if (mem_hit || timeout_hit) state_d = ARB_RESP;
            ARB_RESP:                             state_d = ARB_IDLE;
            default:                              state_d = ARB_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath; everything holds unless a transition touches it.
    always_comb begin
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_read_d   = mem_read;
        mem_addr_d   = mem_addr;
        line_d       = line_out;
        err_d        = err;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    gnt_d      = pick;
                    mem_addr_d = port_req[pick].addr;
                    mem_read_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    mem_read_d = 1'b0;
                end
            end
            ARB_BUSY: begin
                if (mem_hit) begin
                    line_d     = mem_line;
                    mem_read_d = 1'b0;
                    done0_d    = ~gnt_q;
                    done1_d    = gnt_q;
                end else if (timeout_hit) begin
                    mem_read_d = 1'b0;
                    err_d      = 1'b1;
                    done0_d    = ~gnt_q;
                    done1_d    = gnt_q;
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                end
            end
            ARB_RESP: begin
                // Read stays low here so the memory pipeline drains before the next grant.
                mem_read_d   = 1'b0;
                last_grant_d = gnt_q;
            end
            default: begin
                mem_read_d = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; last_grant resets to 1 so port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mem_read     <= 1'b0;
            mem_addr     <= '0;
            line_out     <= '0;
            err          <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
        end else begin
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_read     <= mem_read_d;
            mem_addr     <= mem_addr_d;
            line_out     <= line_d;
            err          <= err_d;
            done0        <= done0_d;
            done1        <= done1_d;
        end
    end

endmodule
